// File: rtl/mem_pkg.sv
// Shared encodings for the RV32I memory-access stage: access sizes, writeback
// source selects and the handshake FSM states.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: store replication/byte enables, load lane
// extraction with sign/zero extension, and misalignment detection.
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] read_data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] lane;

  // Shift the addressed byte/half down to bit 0 before extension.
  assign lane = read_data >> {addr_lo, 3'b000};

  always_comb begin
    wdata      = store_data;
    be         = 4'b1111;
    load_data  = lane;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        wdata     = {4{store_data[7:0]}};
        be        = 4'b0001 << addr_lo;
        load_data = (funct3 == F3_B) ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
      end
      F3_H, F3_HU: begin
        wdata      = {2{store_data[15:0]}};
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        load_data  = (funct3 == F3_H) ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
        misaligned = addr_lo[0];
      end
      // Word and the unused encodings all behave as a full-word access.
      default: misaligned = |addr_lo;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I memory stage: data-memory req/ack handshake with bounded wait, MEM/WB register.
// Latency 1 cycle (zero-wait) or N+1; stallM holds upstream while a request is unacknowledged.
module memory_stage
  import mem_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               validM,
  input  logic               RegWriteM,
  input  logic [1:0]         ResultSrcM,
  input  logic               MemWriteM,
  input  logic [2:0]         funct3M,
  input  logic [D_WIDTH-1:0] ALUResultM,
  input  logic [D_WIDTH-1:0] WriteDataM,
  input  logic [D_WIDTH-1:0] PCPlus4M,
  input  logic [A_WIDTH-1:0] RdM,
  output logic               stallM,
  output logic               mem_req,
  output logic               mem_we,
  output logic [D_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  output logic [3:0]         mem_be,
  input  logic [D_WIDTH-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic               RegWriteW,
  output logic [1:0]         ResultSrcW,
  output logic [D_WIDTH-1:0] ReadDataW,
  output logic [D_WIDTH-1:0] ALUResultW,
  output logic [D_WIDTH-1:0] PCPlus4W,
  output logic [A_WIDTH-1:0] RdW,
  output logic               misalignW,
  output logic               bus_errW
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic               reg_write_q, reg_write_d;
  logic [1:0]         result_src_q, result_src_d;
  logic [D_WIDTH-1:0] read_data_q, read_data_d;
  logic [D_WIDTH-1:0] alu_result_q, alu_result_d;
  logic [D_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [A_WIDTH-1:0] rd_q, rd_d;
  logic               misalign_q, misalign_d;
  logic               bus_err_q, bus_err_d;

  logic mem_op, is_load, misaligned, req, abort, done, capture;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_be;

  load_store_align u_align (
    .funct3     (funct3M),
    .addr_lo    (ALUResultM[1:0]),
    .store_data (WriteDataM),
    .read_data  (mem_rdata),
    .wdata      (st_wdata),
    .be         (st_be),
    .load_data  (ld_data),
    .misaligned (misaligned)
  );

  assign mem_op  = validM & (MemWriteM | (ResultSrcM == RS_MEM));
  assign is_load = (ResultSrcM == RS_MEM) & ~MemWriteM;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        req = mem_op & ~misaligned;
        if (req && !mem_ack) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          req     = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          req   = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with rst_n drops the request the moment reset is asserted mid-wait.
  assign mem_req   = rst_n & req;
  assign done      = mem_req & mem_ack;
  assign stallM    = mem_req & ~mem_ack & ~abort;
  assign mem_we    = mem_req & MemWriteM;
  assign mem_addr  = mem_req ? {ALUResultM[D_WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? st_wdata : '0;
  assign mem_be    = mem_req ? st_be : 4'b0000;

  // Misaligned and aborted accesses never complete, so they fall out as bubbles.
  assign capture = validM & (~mem_op | done);

  always_comb begin
    reg_write_d  = capture & RegWriteM;
    result_src_d = capture ? ResultSrcM : 2'b00;
    read_data_d  = (capture && mem_op && is_load) ? ld_data : '0;
    alu_result_d = capture ? ALUResultM : '0;
    pc_plus4_d   = capture ? PCPlus4M : '0;
    rd_d         = capture ? RdM : '0;
    misalign_d   = mem_op & misaligned;
    bus_err_d    = abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      read_data_q  <= '0;
      alu_result_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign RegWriteW  = reg_write_q;
  assign ResultSrcW = result_src_q;
  assign ReadDataW  = read_data_q;
  assign ALUResultW = alu_result_q;
  assign PCPlus4W   = pc_plus4_q;
  assign RdW        = rd_q;
  assign misalignW  = misalign_q;
  assign bus_errW   = bus_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: single-cycle vector table plus wait, timeout and
// reset-in-wait sequences; MEM/WB expectations flow through a scoreboard queue.
module tb_memory_stage;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic        validM, RegWriteM, MemWriteM, mem_ack;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, mem_rdata;
  logic [4:0]  RdM;
  logic        stallM, mem_req, mem_we, RegWriteW, misalignW, bus_errW;
  logic [31:0] mem_addr, mem_wdata, ReadDataW, ALUResultW, PCPlus4W;
  logic [3:0]  mem_be;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;

  memory_stage #(.D_WIDTH(32), .A_WIDTH(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .validM(validM), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .stallM(stallM), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .ReadDataW(ReadDataW), .ALUResultW(ALUResultW),
    .PCPlus4W(PCPlus4W), .RdW(RdW), .misalignW(misalignW), .bus_errW(bus_errW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] rdata, alu, pc4;
    logic [4:0]  rd;
    logic        mis, berr;
  } wb_t;

  typedef struct {
    logic        v, rw, mw, ack, req, we;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] alu, wd, pc4, rdata, wdata;
    logic [4:0]  rd;
    logic [3:0]  be;
    wb_t         wb;
  } vec_t;

  int  n_checks = 0;
  int  n_pass   = 0;
  wb_t exp_q[$];
  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  function automatic wb_t bubble(input logic mis, input logic berr);
    wb_t w;
    w.rw = 1'b0; w.rs = 2'b00; w.rdata = '0; w.alu = '0; w.pc4 = '0; w.rd = '0;
    w.mis = mis; w.berr = berr;
    return w;
  endfunction

  function automatic wb_t full(input logic rw, input logic [1:0] rs, input logic [31:0] rdata,
                               input logic [31:0] alu, input logic [31:0] pc4, input logic [4:0] rd);
    wb_t w;
    w.rw = rw; w.rs = rs; w.rdata = rdata; w.alu = alu; w.pc4 = pc4; w.rd = rd;
    w.mis = 1'b0; w.berr = 1'b0;
    return w;
  endfunction

  function automatic vec_t mk(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                              input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                              input logic [31:0] pc4, input logic [4:0] rd, input logic [31:0] rdata,
                              input logic ack, input logic cap, input logic req, input logic we,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input logic [31:0] rdw, input logic mis);
    vec_t t;
    t.v = v; t.rw = rw; t.rs = rs; t.mw = mw; t.f3 = f3; t.alu = alu; t.wd = wd; t.pc4 = pc4;
    t.rd = rd; t.rdata = rdata; t.ack = ack; t.req = req; t.we = we; t.be = be; t.wdata = wdata;
    t.wb = cap ? full(rw, rs, rdw, alu, pc4, rd) : bubble(mis, 1'b0);
    return t;
  endfunction

  task automatic set_in(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] pc4, input logic [4:0] rd, input logic [31:0] rdata,
                        input logic ack);
    validM = v; RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; funct3M = f3;
    ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4; RdM = rd; mem_rdata = rdata; mem_ack = ack;
  endtask

  // Advance one edge and compare the MEM/WB outputs against the oldest expectation.
  task automatic tick_check(input string tag);
    wb_t w;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, got RegWriteW=%0b expected a queued entry", tag, RegWriteW);
    end else begin
      w = exp_q.pop_front();
      chk({tag, " RegWriteW"},  32'(RegWriteW),  32'(w.rw));
      chk({tag, " ResultSrcW"}, 32'(ResultSrcW), 32'(w.rs));
      chk({tag, " ReadDataW"},  ReadDataW,       w.rdata);
      chk({tag, " ALUResultW"}, ALUResultW,      w.alu);
      chk({tag, " PCPlus4W"},   PCPlus4W,        w.pc4);
      chk({tag, " RdW"},        32'(RdW),        32'(w.rd));
      chk({tag, " misalignW"},  32'(misalignW),  32'(w.mis));
      chk({tag, " bus_errW"},   32'(bus_errW),   32'(w.berr));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    //            v  rw rs     mw f3     alu           wd            pc4    rd  rdata         ack  cap req we  be       wdata         ReadDataW     mis
    vt[0]  = mk(1, 1, 2'b00, 0, 3'b000, 32'h0000_1234, 32'h0,        32'h08, 5,  32'h0,        0,   1,  0,  0,  4'b0000, 32'h0,        32'h0,        0);
    vt[1]  = mk(1, 1, 2'b01, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h10, 6,  32'h80FF_0000, 1,  1,  1,  0,  4'b1000, 32'h0,        32'hFFFF_FF80, 0);
    vt[2]  = mk(1, 1, 2'b01, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h14, 7,  32'h80FF_0000, 1,  1,  1,  0,  4'b1000, 32'h0,        32'h0000_0080, 0);
    vt[3]  = mk(1, 0, 2'b00, 1, 3'b001, 32'h0000_0102, 32'hABCD_1234, 32'h18, 0, 32'h0,        1,   1,  1,  1,  4'b1100, 32'h1234_1234, 32'h0,        0);
    vt[4]  = mk(1, 1, 2'b01, 0, 3'b001, 32'h0000_0106, 32'h0,        32'h1C, 8,  32'h8001_7FFF, 1,  1,  1,  0,  4'b1100, 32'h0,        32'hFFFF_8001, 0);
    vt[5]  = mk(1, 1, 2'b01, 0, 3'b101, 32'h0000_0106, 32'h0,        32'h20, 9,  32'h8001_7FFF, 1,  1,  1,  0,  4'b1100, 32'h0,        32'h0000_8001, 0);
    vt[6]  = mk(1, 1, 2'b01, 0, 3'b010, 32'h0000_020C, 32'h0,        32'h24, 10, 32'hDEAD_BEEF, 1,  1,  1,  0,  4'b1111, 32'h0,        32'hDEAD_BEEF, 0);
    vt[7]  = mk(1, 0, 2'b00, 1, 3'b000, 32'h0000_0101, 32'h0000_0055, 32'h28, 0, 32'h0,        1,   1,  1,  1,  4'b0010, 32'h5555_5555, 32'h0,        0);
    vt[8]  = mk(1, 0, 2'b00, 1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h2C, 0, 32'h0,        1,   1,  1,  1,  4'b1111, 32'hCAFE_F00D, 32'h0,        0);
    vt[9]  = mk(1, 1, 2'b10, 0, 3'b000, 32'h0000_0999, 32'h0,        32'h44, 1,  32'h0,        0,   1,  0,  0,  4'b0000, 32'h0,        32'h0,        0);
    vt[10] = mk(0, 1, 2'b01, 0, 3'b010, 32'h0000_0300, 32'h0,        32'h48, 3,  32'h1234_5678, 1,  0,  0,  0,  4'b0000, 32'h0,        32'h0,        0);
    vt[11] = mk(1, 1, 2'b01, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h4C, 4,  32'h0,        1,   0,  0,  0,  4'b0000, 32'h0,        32'h0,        1);
    vt[12] = mk(1, 1, 2'b01, 0, 3'b001, 32'h0000_0103, 32'h0,        32'h50, 4,  32'h0,        0,   0,  0,  0,  4'b0000, 32'h0,        32'h0,        1);
    vt[13] = mk(1, 1, 2'b01, 0, 3'b111, 32'h0000_0300, 32'h0,        32'h54, 11, 32'h1234_5678, 1,  1,  1,  0,  4'b1111, 32'h0,        32'h1234_5678, 0);
    vt[14] = mk(1, 1, 2'b01, 0, 3'b011, 32'h0000_0302, 32'h0,        32'h58, 12, 32'h0,        1,   0,  0,  0,  4'b0000, 32'h0,        32'h0,        1);

    rst_n = 1'b0;
    set_in(0, 0, 2'b00, 0, 3'b000, '0, '0, '0, '0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset stallM", 32'(stallM), 32'd0);
    chk("reset RegWriteW", 32'(RegWriteW), 32'd0);
    chk("reset ALUResultW", ALUResultW, 32'd0);
    chk("reset misalignW", 32'(misalignW), 32'd0);
    chk("reset bus_errW", 32'(bus_errW), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      set_in(vt[i].v, vt[i].rw, vt[i].rs, vt[i].mw, vt[i].f3, vt[i].alu, vt[i].wd,
             vt[i].pc4, vt[i].rd, vt[i].rdata, vt[i].ack);
      #1;
      chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vt[i].req));
      chk($sformatf("v%0d stallM", i), 32'(stallM), 32'd0);
      if (vt[i].req) begin
        chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vt[i].we));
        chk($sformatf("v%0d mem_be", i), 32'(mem_be), 32'(vt[i].be));
        chk($sformatf("v%0d mem_wdata", i), mem_wdata, vt[i].wdata);
        chk($sformatf("v%0d mem_addr", i), mem_addr, {vt[i].alu[31:2], 2'b00});
      end
      exp_q.push_back(vt[i].wb);
      tick_check($sformatf("v%0d", i));
    end

    // LW with ack three cycles after the request: stalls for three cycles.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      set_in(1, 1, 2'b01, 0, 3'b010, 32'h0000_0200, 32'h0, 32'h60, 12,
             (c == 3) ? 32'h1122_3344 : 32'hBAD0_0000, c == 3);
      #1;
      chk($sformatf("wait c%0d mem_req", c), 32'(mem_req), 32'd1);
      chk($sformatf("wait c%0d stallM", c), 32'(stallM), (c == 3) ? 32'd0 : 32'd1);
      chk($sformatf("wait c%0d mem_addr", c), mem_addr, 32'h0000_0200);
      chk($sformatf("wait c%0d mem_be", c), 32'(mem_be), 32'hF);
      chk($sformatf("wait c%0d mem_we", c), 32'(mem_we), 32'd0);
      exp_q.push_back((c == 3) ? full(1, 2'b01, 32'h1122_3344, 32'h200, 32'h60, 12) : bubble(0, 0));
      tick_check($sformatf("wait c%0d", c));
    end
    @(negedge clk);
    set_in(0, 0, 2'b00, 0, 3'b000, '0, '0, '0, '0, '0, 0);
    exp_q.push_back(bubble(0, 0));
    tick_check("wait drain");

    // No ack: the request cycle plus TO-1 waiting cycles stall, then the TO-th waiting cycle aborts.
    for (int c = 0; c <= TO; c++) begin
      @(negedge clk);
      set_in(1, 1, 2'b01, 0, 3'b010, 32'h0000_0300, 32'h0, 32'h70, 13, 32'h0, 0);
      #1;
      chk($sformatf("timeout c%0d mem_req", c), 32'(mem_req), (c < TO) ? 32'd1 : 32'd0);
      chk($sformatf("timeout c%0d stallM", c), 32'(stallM), (c < TO) ? 32'd1 : 32'd0);
      exp_q.push_back(bubble(0, c == TO));
      tick_check($sformatf("timeout c%0d", c));
    end
    @(negedge clk);
    set_in(0, 0, 2'b00, 0, 3'b000, '0, '0, '0, '0, '0, 0);
    exp_q.push_back(bubble(0, 0));
    tick_check("timeout drain");

    // Reset while waiting: the request drops without waiting for a clock edge.
    @(negedge clk);
    set_in(1, 1, 2'b01, 0, 3'b010, 32'h0000_0400, 32'h0, 32'h80, 14, 32'h0, 0);
    exp_q.push_back(bubble(0, 0));
    tick_check("rstwait c0");
    @(negedge clk);
    #1;
    chk("rstwait in WAIT mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwait mem_req", 32'(mem_req), 32'd0);
    chk("rstwait stallM", 32'(stallM), 32'd0);
    chk("rstwait RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rstwait ReadDataW", ReadDataW, 32'd0);
    chk("rstwait bus_errW", 32'(bus_errW), 32'd0);
    @(negedge clk);
    set_in(0, 0, 2'b00, 0, 3'b000, '0, '0, '0, '0, 32'h5555_5555, 1);
    rst_n = 1'b1;
    #1;
    chk("rstwait post mem_req", 32'(mem_req), 32'd0);
    exp_q.push_back(bubble(0, 0));
    tick_check("rstwait post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
